muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It is the sequential, parametrised successor to the combinational Adder.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- Sits beside the ALU in EX. The pipeline control stalls on busy; the forwarding path muxes hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, default 32: operand width and HI/LO width; must be >= 2.
- CNT_W, default $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin operation; sampled only while busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand: multiplicand or dividend.
- b  input  WIDTH  rt operand: multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and work registers cleared.
  - Takes effect immediately, including mid-operation. The aborted result is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 at an edge (E0): latch op.
  - For signed ops (op[0]=0), latch |a| and |b| as WIDTH-bit unsigned magnitudes. |MIN| = 2^(WIDTH-1), carried unsigned. Also latch the result-sign flags.
  - Load counter=WIDTH, go to RUN. busy=1 from E0 onward.
- RUN:
  - One radix-2 step per edge (E1..E_WIDTH); counter decrements each step.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, partial remainder in the high half.
  - When counter reaches 0 after E_WIDTH, go to FINISH.
- FINISH:
  - At edge E_(WIDTH+1), apply sign fix-up and write hi/lo. Then done=1 for exactly that one following cycle, busy=0, return to IDLE.
  - Total latency: start edge to result visible is WIDTH+1 edges; busy is high for WIDTH+1 cycles.
  - A new start may be sampled at E_(WIDTH+2), i.e. the cycle in which done=1.
- Sign rules:
  - MULT: 2*WIDTH product is negated if sign(a) XOR sign(b).
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no fix-up.
- Arithmetic boundaries:
  - Divide by zero, any op: lo = all ones, hi = a (original operand value). No sign fix-up. Same latency as a normal divide.
  - DIV of MIN by -1: lo = MIN, hi = 0 (wraps, no trap).
  - MULT of MIN by MIN: hi = 2^(WIDTH-2), lo = 0.
- start while busy=1: ignored; the operation in flight is unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; register = wdata at the next edge; done not pulsed.
  - Both may write in the same cycle.
  - Ignored while busy.
  - Ignored if start=1 in the same cycle: start wins.
- hi/lo outputs:
  - Hold their values throughout RUN (old result visible until FINISH).
  - Driven directly from registers; no combinational path from inputs.
- op values are all legal; the unit has no error output.

Test Plan (WIDTH=32):
1. MULT a=0xFFFFFFFD (-3), b=0x00000007, start at E0 -> busy=1 E0..E33; at E33 hi=0xFFFFFFFF, lo=0xFFFFFFEB; done=1 for one cycle only.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=100, b=7 -> lo=14, hi=2.
4. DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 33 edges. DIV a=0xFFFFFFF0, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF0.
5. Handshake/MT:
   - In IDLE, hi_we=1, wdata=0xDEADBEEF -> hi=0xDEADBEEF next edge, lo unchanged, done=0.
   - During RUN: start=1 with new operands and lo_we=1 -> both ignored; result matches the original op.
   - start+hi_we same idle cycle -> operation starts, hi not written.
6. Start MULTU, drop rst_n at E10 between edges -> busy=0, done=0, hi=lo=0 immediately (before the next clk edge).
   - Release rst_n, issue DIVU 9/3 -> lo=3, hi=0 with full 33-edge latency.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and register-access bundle between the EX stage and the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the FINISH cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave io
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int W2    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             busy;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_s, sub_t, sub_s;
    logic [W2-1:0]    mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0] quo, rem;

    assign sgn_a = ~io.op[0] & io.a[WIDTH-1];
    assign sgn_b = ~io.op[0] & io.b[WIDTH-1];
    assign mag_a = sgn_a ? -io.a : io.a;
    assign mag_b = sgn_b ? -io.b : io.b;

    // Multiply: add multiplicand into the top half, shift right.
    assign add_s   = {1'b0, acc_q[W2-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_nxt = {add_s, acc_q[WIDTH-1:1]};

    // Divide: shift left, trial-subtract divisor, restore on borrow.
    assign sub_t   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign sub_s   = sub_t - {1'b0, opnd_q};
    assign div_nxt = (sub_t >= {1'b0, opnd_q})
                   ? {sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                   : {sub_t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == FINISH);
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        orig_d   = orig_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    is_div_d = io.op[1];
                    neg_d    = sgn_a ^ sgn_b;
                    rneg_d   = sgn_a;
                    dz_d     = (io.b == '0);
                    orig_d   = io.a;
                    cnt_d    = CNT_W'(WIDTH);
                    acc_d    = {{WIDTH{1'b0}}, io.op[1] ? mag_a : mag_b};
                    opnd_d   = io.op[1] ? mag_b : mag_a;
                end else begin
                    if (io.hi_we) hi_d = io.wdata;
                    if (io.lo_we) lo_d = io.wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = is_div_q ? div_nxt : mul_nxt;
            end
            FINISH: begin
                if (!is_div_q) begin
                    hi_d = prod[W2-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            orig_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            orig_q   <= orig_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign io.busy = busy;
    assign io.done = done_q;
    assign io.hi   = hi_q;
    assign io.lo   = lo_q;
endmodule
